// File: rtl/ysyx_24100005_en_reg.sv
// ---------------------------------------------------------------------------
// ysyx_24100005_en_reg
//
// Width-generic storage register with write enable and synchronous reset to
// a configurable value. It is the basic state element of the NPC core: the
// program counter uses WIDTH=32, RESET_VAL=32'h8000_0000, STAGES=1. Other
// pipeline registers use the same block.
//
// The block holds STAGES cascaded registers. dout is taken from the last one,
// so a write needs STAGES enabled edges to travel from din to dout.
//
// Parameters:
//   WIDTH     - data width in bits (legal range 1..1024)
//   RESET_VAL - value loaded into every stage on reset (WIDTH bits)
//   STAGES    - number of cascaded stages (legal range 1..16)
//
// Ports:
//   clk  - clock; all state changes happen on the rising edge
//   rst  - synchronous, active-high reset; overrides wen
//   din  - value fed into the first stage
//   wen  - write enable; advances the whole chain at once
//   dout - contents of the last stage, driven directly from flops
// ---------------------------------------------------------------------------
module ysyx_24100005_en_reg #(
    parameter int unsigned             WIDTH     = 1,
    parameter logic [WIDTH-1:0]        RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned             STAGES    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wen,
    output logic [WIDTH-1:0] dout
);

    // stage_in_s[i] is what stage i captures on an enabled edge: din for the
    // first stage, the previous stage's contents for all later ones.
    logic [WIDTH-1:0] stage_r    [STAGES];
    logic [WIDTH-1:0] stage_in_s [STAGES];

    assign stage_in_s[0] = din;

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi = gi + 1) begin : g_link
            assign stage_in_s[gi] = stage_r[gi-1];
        end

        for (gi = 0; gi < STAGES; gi = gi + 1) begin : g_stage
            // Stage register: reset wins over write, write shifts, else hold.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_r[gi] <= RESET_VAL;
                end else if (wen) begin
                    stage_r[gi] <= stage_in_s[gi];
                end else begin
                    stage_r[gi] <= stage_r[gi];
                end
            end
        end
    endgenerate

    assign dout = stage_r[STAGES-1];

    ysyx_24100005_en_reg_chk #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_chk (
        .clk (clk),
        .rst (rst),
        .wen (wen)
    );

endmodule

// ---------------------------------------------------------------------------
// ysyx_24100005_en_reg_chk
//
// Simulation-side checks for ysyx_24100005_en_reg. Illegal parameter sets stop
// elaboration; an unknown control value at a clock edge outside of reset is
// reported as a warning and otherwise left to the simulator's X semantics.
//
// Ports:
//   clk - clock of the checked register
//   rst - reset of the checked register
//   wen - write enable of the checked register
// ---------------------------------------------------------------------------
module ysyx_24100005_en_reg_chk #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic wen
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "ysyx_24100005_en_reg: WIDTH must be at least 1");
        end
        if ((STAGES < 1) || (STAGES > 16)) begin : g_bad_stages
            $fatal(1, "ysyx_24100005_en_reg: STAGES must be within 1..16");
        end
    endgenerate

    // Warn on unknown rst/wen at an edge where the register is not held in reset.
    always_ff @(posedge clk) begin
        if (rst !== 1'b1) begin
            assert (!$isunknown({rst, wen}))
            else $warning("ysyx_24100005_en_reg: X on rst or wen at clock edge");
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_en_reg.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24100005_en_reg
//
// Directed bench for ysyx_24100005_en_reg. Four instances cover the PC
// configuration, a three-stage 8-bit chain and the 1-bit / 64-bit widths.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_ysyx_24100005_en_reg;

    logic clk;
    int   total;
    int   bad;

    // PC instance: WIDTH=32, RESET_VAL=0x8000_0000, STAGES=1
    logic        pc_rst, pc_wen;
    logic [31:0] pc_din, pc_dout;
    // Multi-stage instance: WIDTH=8, RESET_VAL=0xA5, STAGES=3
    logic        ms_rst, ms_wen;
    logic [7:0]  ms_din, ms_dout;
    // 1-bit instance: RESET_VAL=1
    logic        w1_rst, w1_wen;
    logic        w1_din, w1_dout;
    // 64-bit instance
    logic        w64_rst, w64_wen;
    logic [63:0] w64_din, w64_dout;

    ysyx_24100005_en_reg #(.WIDTH(32), .RESET_VAL(32'h8000_0000), .STAGES(1)) u_pc (
        .clk(clk), .rst(pc_rst), .din(pc_din), .wen(pc_wen), .dout(pc_dout));

    ysyx_24100005_en_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .STAGES(3)) u_ms (
        .clk(clk), .rst(ms_rst), .din(ms_din), .wen(ms_wen), .dout(ms_dout));

    ysyx_24100005_en_reg #(.WIDTH(1), .RESET_VAL(1'b1), .STAGES(1)) u_w1 (
        .clk(clk), .rst(w1_rst), .din(w1_din), .wen(w1_wen), .dout(w1_dout));

    ysyx_24100005_en_reg #(.WIDTH(64), .RESET_VAL(64'h8000_0000_0000_0001), .STAGES(1)) u_w64 (
        .clk(clk), .rst(w64_rst), .din(w64_din), .wen(w64_wen), .dout(w64_dout));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        pc_rst = 1'b1; pc_wen = 1'b1; pc_din = 32'h1234_5678;
        step();
        total++;
        if (pc_dout !== 32'h8000_0000) begin
            bad++;
            $display("FAIL reset_edge1: got %h expected %h", pc_dout, 32'h8000_0000);
        end
        step();
        total++;
        if (pc_dout !== 32'h8000_0000) begin
            bad++;
            $display("FAIL reset_edge2: got %h expected %h", pc_dout, 32'h8000_0000);
        end
    endtask

    task automatic test_pc_increment();
        logic [31:0] exp_v [3];
        exp_v[0] = 32'h8000_0004;
        exp_v[1] = 32'h8000_0008;
        exp_v[2] = 32'h8000_000C;
        pc_rst = 1'b0; pc_wen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_din = pc_dout + 32'd4;
            step();
            total++;
            if (pc_dout !== exp_v[i]) begin
                bad++;
                $display("FAIL pc_inc[%0d]: got %h expected %h", i, pc_dout, exp_v[i]);
            end
        end
    endtask

    task automatic test_enable_gating();
        pc_rst = 1'b0; pc_wen = 1'b1; pc_din = 32'hDEAD_BEEF;
        step();
        total++;
        if (pc_dout !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL gate_load: got %h expected %h", pc_dout, 32'hDEAD_BEEF);
        end
        pc_wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_din = 32'h0BAD_0000 + i;
            step();
            total++;
            if (pc_dout !== 32'hDEAD_BEEF) begin
                bad++;
                $display("FAIL gate_hold[%0d]: got %h expected %h", i, pc_dout, 32'hDEAD_BEEF);
            end
        end
        pc_wen = 1'b1; pc_din = 32'h0000_0001;
        step();
        total++;
        if (pc_dout !== 32'h0000_0001) begin
            bad++;
            $display("FAIL gate_resume: got %h expected %h", pc_dout, 32'h0000_0001);
        end
    endtask

    task automatic test_reset_midstream();
        pc_rst = 1'b0; pc_wen = 1'b1; pc_din = 32'h8000_0010;
        step();
        total++;
        if (pc_dout !== 32'h8000_0010) begin
            bad++;
            $display("FAIL mid_preload: got %h expected %h", pc_dout, 32'h8000_0010);
        end
        pc_rst = 1'b1; pc_wen = 1'b1; pc_din = 32'hFFFF_FFFF;
        step();
        total++;
        if (pc_dout !== 32'h8000_0000) begin
            bad++;
            $display("FAIL mid_reset_wins: got %h expected %h", pc_dout, 32'h8000_0000);
        end
        pc_rst = 1'b0;
        step();
        total++;
        if (pc_dout !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL mid_capture_wrap: got %h expected %h", pc_dout, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_multi_stage();
        logic [7:0] din_v [8];
        logic       wen_v [8];
        logic [7:0] exp_v [8];
        // din 01,02,03 fill the chain; 04 pushes 02 out; two bubbles stall;
        // 05,06 resume with 03,04 emerging.
        din_v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h77, 8'h88, 8'h05, 8'h06};
        wen_v = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
        exp_v = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04};
        ms_rst = 1'b1; ms_wen = 1'b1; ms_din = 8'h3C;
        step();
        total++;
        if (ms_dout !== 8'hA5) begin
            bad++;
            $display("FAIL ms_reset: got %h expected %h", ms_dout, 8'hA5);
        end
        ms_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ms_din = din_v[i];
            ms_wen = wen_v[i];
            step();
            total++;
            if (ms_dout !== exp_v[i]) begin
                bad++;
                $display("FAIL ms_chain[%0d]: got %h expected %h", i, ms_dout, exp_v[i]);
            end
        end
        // Reset mid-stream discards all in-flight data.
        ms_rst = 1'b1; ms_wen = 1'b1; ms_din = 8'h99;
        step();
        ms_rst = 1'b0; ms_wen = 1'b0;
        step();
        total++;
        if (ms_dout !== 8'hA5) begin
            bad++;
            $display("FAIL ms_flush: got %h expected %h", ms_dout, 8'hA5);
        end
    endtask

    task automatic test_width_edges();
        w1_rst = 1'b1; w1_wen = 1'b0; w1_din = 1'b0;
        step();
        total++;
        if (w1_dout !== 1'b1) begin
            bad++;
            $display("FAIL w1_reset: got %b expected %b", w1_dout, 1'b1);
        end
        w1_rst = 1'b0; w1_wen = 1'b1; w1_din = 1'b0;
        step();
        total++;
        if (w1_dout !== 1'b0) begin
            bad++;
            $display("FAIL w1_write: got %b expected %b", w1_dout, 1'b0);
        end
        w64_rst = 1'b1; w64_wen = 1'b1; w64_din = 64'h0123_4567_89AB_CDEF;
        step();
        total++;
        if (w64_dout !== 64'h8000_0000_0000_0001) begin
            bad++;
            $display("FAIL w64_reset: got %h expected %h", w64_dout, 64'h8000_0000_0000_0001);
        end
        w64_rst = 1'b0; w64_wen = 1'b1; w64_din = 64'hFEDC_BA98_7654_3210;
        step();
        total++;
        if (w64_dout !== 64'hFEDC_BA98_7654_3210) begin
            bad++;
            $display("FAIL w64_write: got %h expected %h", w64_dout, 64'hFEDC_BA98_7654_3210);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        pc_rst  = 1'b1; pc_wen  = 1'b0; pc_din  = 32'h0;
        ms_rst  = 1'b1; ms_wen  = 1'b0; ms_din  = 8'h0;
        w1_rst  = 1'b1; w1_wen  = 1'b0; w1_din  = 1'b0;
        w64_rst = 1'b1; w64_wen = 1'b0; w64_din = 64'h0;
        #1;
        test_reset();
        test_pc_increment();
        test_enable_gating();
        test_reset_midstream();
        test_multi_stage();
        test_width_edges();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_en_reg.md
# ysyx_24100005_en_reg

Parameterized, width-generic storage register with synchronous active-high reset to a configurable value and a write enable. It is the basic state element of the NPC core. Its primary use is the program counter: 32 bits wide, reset to 0x8000_0000, written every cycle with PC+4. All other architectural and pipeline registers in the core use the same block, so its behaviour must be exact for any legal parameter set.

## Interface
Parameters:
- WIDTH, default 1: data width in bits. Legal range is 1..1024.
- RESET_VAL, default 0: value loaded on reset. It is WIDTH bits wide. Bits above WIDTH are ignored.
- STAGES, default 1: number of cascaded register stages between din and dout. Legal range is 1..16. The PC instance uses 1.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: clock. All state changes on the rising edge only.
- rst, in, 1: synchronous, active-high reset. It is sampled on the rising edge of clk.
- din, in, WIDTH: next value to store.
- wen, in, 1: write enable, active-high.
- dout, out, WIDTH: current register contents, driven directly from flops.

## Operation
- State consists of STAGES registers, r[0]..r[STAGES-1], each WIDTH bits. dout = r[STAGES-1].
- On each rising edge of clk, with priority from highest to lowest:
  - rst=1: every stage loads RESET_VAL. This happens regardless of wen and din.
  - rst=0, wen=1: r[0] loads din, and each r[i] loads r[i-1] for i≥1. All stages shift together.
  - rst=0, wen=0: all stages hold their value.
- wen gates the whole chain. There is no partial or per-stage enable.
- dout is purely registered. There is no combinational path from din, wen or rst to dout.
- Width rules: no arithmetic is performed. Values are stored bit-exact, with no sign extension or truncation beyond WIDTH.
- Before the first reset edge, contents are undefined (X in simulation). The block does not rely on initial blocks.
- Simulation-only elaboration checks are required. They raise $fatal for:
  - WIDTH<1
  - STAGES<1 or STAGES>16
- X on wen or rst at a clock edge, while not in reset, raises a $display warning and has no defined effect on state.

## Timing
- Reset: dout = RESET_VAL starting from the first rising edge at which rst=1, and remains there while rst stays high.
- Write latency: STAGES rising edges from din to dout, counting only edges with wen=1. With STAGES=1, din sampled at edge N appears on dout just after edge N.
- Reset released: the first edge with rst=0 and wen=1 captures din. For the PC, with din=PC+4, the sequence is 0x8000_0000 → 0x8000_0004 → 0x8000_0008 → …
- Reset asserted mid-operation: takes effect at the next edge and overrides any simultaneous write. All in-flight stage data is discarded.
- Reset and wen asserted in the same cycle: reset wins.
- Hold: with wen=0, dout stays stable indefinitely.
- Wrap-around: the block does not saturate. For example, 0xFFFF_FFFF loaded as din is stored as-is, and the PC+4 wrap is handled outside the block.

## Test plan
- Reset: WIDTH=32, RESET_VAL=0x8000_0000, STAGES=1. Hold rst=1 for 2 edges with din=0x1234_5678 and wen=1 → dout=0x8000_0000 after the first edge, and unchanged after the second.
- PC increment loop: din=dout+4, wen=1, rst deasserted → dout reads 0x8000_0004, 0x8000_0008, 0x8000_000C on successive edges.
- Enable gating: load 0xDEAD_BEEF, then wen=0 for 3 edges while din varies → dout stays 0xDEAD_BEEF. Then wen=1 with din=0x0000_0001 → dout=0x0000_0001 after 1 edge.
- Reset mid-stream with simultaneous write: dout=0x8000_0010, rst=1, wen=1, din=0xFFFF_FFFF → dout=0x8000_0000 after that edge. din=0xFFFF_FFFF is captured on the next edge with rst=0.
- Multi-stage: STAGES=3, WIDTH=8, RESET_VAL=0xA5. After reset, write 0x01, 0x02, 0x03 on consecutive edges → dout reads 0xA5, 0xA5, 0x01, then 0x02 on the next edge. A wen=0 bubble stalls the whole chain.
- Width edge cases: WIDTH=1, RESET_VAL=1, reset then write 0 → dout goes 1 then 0. A second instance with WIDTH=64 and RESET_VAL=0x8000_0000_0000_0001 resets to that exact value.
